// File: rtl/input_mapper.sv
// Maps PS/2 key events and two hps_io joysticks onto two conditioned 11-bit player vectors.
// Optional joystick debouncing is enabled by defining INPUT_DEBOUNCE_EN.
module input_mapper #(
  parameter logic [15:0] COIN_CYCLES     = 16'd4800,
  parameter bit          SOCD_NEUTRAL    = 1'b1,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  output logic [10:0] player_1,
  output logic [10:0] player_2
);

  logic             init_q, init_d;
  logic             toggle_q, toggle_d;
  logic [1:0][10:0] key_q, key_d;
  logic [1:0][10:0] joy;
  logic [1:0][10:0] plr;
  logic             map_hit;
  logic             map_plr;
  logic [3:0]       map_bit;

  // Upper joystick bits and the extended-key flag carry nothing we use.
  logic unused_bits;

  always_comb begin
    {map_hit, map_plr, map_bit} = 6'd0;
    case (ps2_key[7:0])
      8'h74: {map_hit, map_plr, map_bit} = {2'b10, 4'd0};
      8'h6B: {map_hit, map_plr, map_bit} = {2'b10, 4'd1};
      8'h72: {map_hit, map_plr, map_bit} = {2'b10, 4'd2};
      8'h75: {map_hit, map_plr, map_bit} = {2'b10, 4'd3};
      8'h14: {map_hit, map_plr, map_bit} = {2'b10, 4'd4};
      8'h11: {map_hit, map_plr, map_bit} = {2'b10, 4'd5};
      8'h29: {map_hit, map_plr, map_bit} = {2'b10, 4'd6};
      8'h12: {map_hit, map_plr, map_bit} = {2'b10, 4'd7};
      8'h16: {map_hit, map_plr, map_bit} = {2'b10, 4'd8};
      8'h2E: {map_hit, map_plr, map_bit} = {2'b10, 4'd9};
      8'h4D: {map_hit, map_plr, map_bit} = {2'b10, 4'd10};
      8'h34: {map_hit, map_plr, map_bit} = {2'b11, 4'd0};
      8'h23: {map_hit, map_plr, map_bit} = {2'b11, 4'd1};
      8'h2B: {map_hit, map_plr, map_bit} = {2'b11, 4'd2};
      8'h2D: {map_hit, map_plr, map_bit} = {2'b11, 4'd3};
      8'h1C: {map_hit, map_plr, map_bit} = {2'b11, 4'd4};
      8'h1B: {map_hit, map_plr, map_bit} = {2'b11, 4'd5};
      8'h15: {map_hit, map_plr, map_bit} = {2'b11, 4'd6};
      8'h1D: {map_hit, map_plr, map_bit} = {2'b11, 4'd7};
      8'h1E: {map_hit, map_plr, map_bit} = {2'b11, 4'd8};
      8'h36: {map_hit, map_plr, map_bit} = {2'b11, 4'd9};
      default: ;
    endcase
  end

  // The first cycle after reset only resynchronises the toggle copy.
  always_comb begin
    init_d   = 1'b0;
    toggle_d = toggle_q;
    key_d    = key_q;
    if (init_q) begin
      toggle_d = ps2_key[10];
    end else if (ps2_key[10] != toggle_q) begin
      toggle_d = ps2_key[10];
      if (map_hit) key_d[map_plr][map_bit] = ps2_key[9];
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      init_q   <= 1'b1;
      toggle_q <= 1'b0;
      key_q    <= '0;
    end else begin
      init_q   <= init_d;
      toggle_q <= toggle_d;
      key_q    <= key_d;
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [21:0] db_in;
  logic [21:0] db_out;

  assign db_in  = {joystick_1[10:0], joystick_0[10:0]};
  assign joy[0] = db_out[10:0];
  assign joy[1] = db_out[21:11];
  assign unused_bits = ^{joystick_0[31:11], joystick_1[31:11], ps2_key[8]};

  genvar gi;
  generate
    for (gi = 0; gi < 22; gi++) begin : g_db
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            stable_q, stable_d;

      // cnt counts consecutive cycles the input has disagreed with the accepted level.
      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (db_in[gi] != stable_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) stable_d = db_in[gi];
          else cnt_d = cnt_q + DB_W'(1);
        end
      end

      always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
        end
      end

      assign db_out[gi] = stable_q;
    end
  endgenerate
`else
  assign joy[0] = joystick_0[10:0];
  assign joy[1] = joystick_1[10:0];
  assign unused_bits = ^{joystick_0[31:11], joystick_1[31:11], ps2_key[8], DEBOUNCE_CYCLES[0]};
  genvar gi;
`endif

  generate
    for (gi = 0; gi < 2; gi++) begin : g_plr
      logic [10:0] raw;
      logic [10:0] player_q, player_d;
      logic [15:0] coin_cnt_q, coin_cnt_d;
      logic        coin_prev_q, coin_prev_d;
      logic        pause_prev_q, pause_prev_d;

      always_comb begin
        raw      = key_q[gi] | joy[gi];
        player_d = raw;
        if (SOCD_NEUTRAL) begin
          if (raw[3] && raw[2]) player_d[3:2] = 2'b00;
          if (raw[1] && raw[0]) player_d[1:0] = 2'b00;
        end
        // A coin edge only arms the counter when idle; holding past expiry gives no second pulse.
        coin_cnt_d = coin_cnt_q;
        if (coin_cnt_q != 16'd0)          coin_cnt_d = coin_cnt_q - 16'd1;
        else if (raw[9] && !coin_prev_q)  coin_cnt_d = COIN_CYCLES;
        player_d[9]  = (coin_cnt_d != 16'd0);
        player_d[10] = player_q[10] ^ (raw[10] && !pause_prev_q);
        coin_prev_d  = raw[9];
        pause_prev_d = raw[10];
      end

      always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
          player_q     <= '0;
          coin_cnt_q   <= '0;
          coin_prev_q  <= 1'b0;
          pause_prev_q <= 1'b0;
        end else begin
          player_q     <= player_d;
          coin_cnt_q   <= coin_cnt_d;
          coin_prev_q  <= coin_prev_d;
          pause_prev_q <= pause_prev_d;
        end
      end

      assign plr[gi] = player_q;
    end
  endgenerate

  assign player_1 = plr[0];
  assign player_2 = plr[1];

endmodule

// File: tb/tb_input_mapper.sv
// Randomised and directed bench for input_mapper (default build, COIN_CYCLES = 8),
// checked every cycle against a cycle-level reference model of the key/joystick rules.
module tb_input_mapper;

  localparam int COIN_N = 8;

  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic [31:0] joystick_0 = '0;
  logic [31:0] joystick_1 = '0;
  logic [10:0] player_1;
  logic [10:0] player_2;

  input_mapper #(.COIN_CYCLES(16'(COIN_N)), .SOCD_NEUTRAL(1'b1), .DEBOUNCE_CYCLES(4)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .player_1(player_1), .player_2(player_2)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit        m_init;
  bit        m_tog;
  bit [10:0] m_keys [2];
  bit [10:0] m_out  [2];
  bit        m_cprev [2];
  bit        m_pprev [2];
  int        m_coin_start [2];
  int        cyc = 0;
  bit        ps2_tog = 1'b1;

  function automatic void lookup(input bit [7:0] code, output int p, output int b);
    p = -1; b = 0;
    case (code)
      8'h74: begin p = 0; b = 0;  end  8'h6B: begin p = 0; b = 1;  end
      8'h72: begin p = 0; b = 2;  end  8'h75: begin p = 0; b = 3;  end
      8'h14: begin p = 0; b = 4;  end  8'h11: begin p = 0; b = 5;  end
      8'h29: begin p = 0; b = 6;  end  8'h12: begin p = 0; b = 7;  end
      8'h16: begin p = 0; b = 8;  end  8'h2E: begin p = 0; b = 9;  end
      8'h4D: begin p = 0; b = 10; end
      8'h34: begin p = 1; b = 0;  end  8'h23: begin p = 1; b = 1;  end
      8'h2B: begin p = 1; b = 2;  end  8'h2D: begin p = 1; b = 3;  end
      8'h1C: begin p = 1; b = 4;  end  8'h1B: begin p = 1; b = 5;  end
      8'h15: begin p = 1; b = 6;  end  8'h1D: begin p = 1; b = 7;  end
      8'h1E: begin p = 1; b = 8;  end  8'h36: begin p = 1; b = 9;  end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_init = 1'b1;
    m_tog  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_keys[p] = '0; m_out[p] = '0; m_cprev[p] = 1'b0; m_pprev[p] = 1'b0;
      m_coin_start[p] = -100000;
    end
  endtask

  task automatic model_step();
    bit [10:0] joy [2];
    bit [10:0] nxt [2];
    bit [10:0] raw;
    int p, b;
    joy[0] = joystick_0[10:0];
    joy[1] = joystick_1[10:0];
    cyc++;
    for (int i = 0; i < 2; i++) begin
      raw = m_keys[i] | joy[i];
      nxt[i] = raw;
      if (raw[3] && raw[2]) begin nxt[i][3] = 0; nxt[i][2] = 0; end
      if (raw[1] && raw[0]) begin nxt[i][1] = 0; nxt[i][0] = 0; end
      // A new press starts a pulse only if no pulse was showing last cycle.
      if (raw[9] && !m_cprev[i] && !m_out[i][9]) m_coin_start[i] = cyc;
      nxt[i][9]  = (cyc - m_coin_start[i]) < COIN_N;
      nxt[i][10] = m_out[i][10] ^ (raw[10] && !m_pprev[i]);
      m_cprev[i] = raw[9];
      m_pprev[i] = raw[10];
    end
    if (m_init) begin
      m_init = 1'b0;
      m_tog  = ps2_key[10];
    end else if (ps2_key[10] != m_tog) begin
      m_tog = ps2_key[10];
      lookup(ps2_key[7:0], p, b);
      if (p >= 0) m_keys[p][b] = ps2_key[9];
    end
    m_out[0] = nxt[0];
    m_out[1] = nxt[1];
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (RESET) model_reset();
    else model_step();
    #1;
    check("p1", {21'd0, player_1}, {21'd0, m_out[0]});
    check("p2", {21'd0, player_2}, {21'd0, m_out[1]});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ps2_event(input bit [7:0] code, input bit pressed, input bit ext);
    ps2_tog = ~ps2_tog;
    ps2_key = {ps2_tog, pressed, ext, code};
  endtask

  bit [7:0] codes [24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12,
                           8'h16, 8'h2E, 8'h4D, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C,
                           8'h1B, 8'h15, 8'h1D, 8'h1E, 8'h36, 8'h5A, 8'h76, 8'h00};

  initial begin
    int hi;
    model_reset();
    // Reset held with the PS/2 toggle already high.
    ticks(3);
    check("rst_p1", {21'd0, player_1}, 32'h0);
    check("rst_p2", {21'd0, player_2}, 32'h0);
    @(negedge clk_sys); RESET = 1'b0;
    ticks(4);
    check("post_rst_p1", {21'd0, player_1}, 32'h0);
    check("post_rst_p2", {21'd0, player_2}, 32'h0);

    // Keyboard up: two-cycle latency.
    ps2_event(8'h75, 1'b1, 1'b0);
    tick();
    check("up_lat1", {31'd0, player_1[3]}, 32'd0);
    tick();
    check("up_press", {31'd0, player_1[3]}, 32'd1);
    ps2_event(8'h75, 1'b0, 1'b0);
    ticks(2);
    check("up_release", {31'd0, player_1[3]}, 32'd0);

    // SOCD and one-cycle joystick latency.
    joystick_0 = 32'h3;
    tick();
    check("socd_lr", {30'd0, player_1[1:0]}, 32'd0);
    joystick_0 = 32'h1;
    tick();
    check("joy_right", {31'd0, player_1[0]}, 32'd1);
    joystick_0 = 32'h0;
    tick();

    // Coin held 20 cycles gives one 8-cycle pulse; a re-press gives another.
    for (int rep = 0; rep < 2; rep++) begin
      joystick_1 = 32'h200;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (player_2[9]) hi++;
      end
      check("coin_len", hi, COIN_N);
      joystick_1 = 32'h0;
      ticks(3);
    end

    // Pause toggles on each press.
    ps2_event(8'h4D, 1'b1, 1'b0); ticks(2);
    ps2_event(8'h4D, 1'b0, 1'b0); ticks(2);
    check("pause_on", {31'd0, player_1[10]}, 32'd1);
    ps2_event(8'h4D, 1'b1, 1'b0); ticks(2);
    ps2_event(8'h4D, 1'b0, 1'b0); ticks(2);
    check("pause_off", {31'd0, player_1[10]}, 32'd0);
    ps2_event(8'h4D, 1'b1, 1'b0); ticks(2);
    check("pause_on2", {31'd0, player_1[10]}, 32'd1);
    // Asynchronous reset clears the latch without a clock edge.
    RESET = 1'b1;
    #1;
    check("pause_async_rst", {21'd0, player_1}, 32'h0);
    model_reset();
    ticks(2);
    @(negedge clk_sys); RESET = 1'b0;
    ticks(3);
    check("key_cleared", {21'd0, player_1}, 32'h0);

    // Coin pulse aborted by reset.
    joystick_0 = 32'h200;
    ticks(3);
    check("coin_mid", {31'd0, player_1[9]}, 32'd1);
    RESET = 1'b1;
    #1;
    check("coin_abort", {31'd0, player_1[9]}, 32'd0);
    model_reset();
    ticks(1);
    @(negedge clk_sys); RESET = 1'b0; joystick_0 = 32'h0;
    ticks(2);

    // Random mix of keyboard events and joystick traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) joystick_0 = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 4) == 0) joystick_1 = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0)
        ps2_event(codes[$urandom_range(0, 23)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
